ram_display_bridge: RTL and testbench

Parametrised successor to the fabric-side single-port RAM with debug display. Holds a 2**ADDR_W x DATA_W on-chip RAM shared by two masters: a host request channel driven from the HPS bridge side, and an internal scan engine. The scan engine periodically reads fixed addresses and drives LEDR and NUM_HEX seven-segment displays. The block also clears the RAM after reset and arbitrates host versus scan access with a starvation guard.

---
 rtl/ram_display_pkg.sv | 18 +
 rtl/seg7_decode.sv | 12 +
 rtl/ram_display_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_ram_display_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_display_pkg.sv
// Shared types and constants for the RAM display bridge: FSM states and the
// active-low seven-segment glyph table (gfedcba order).
package ram_display_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder with a blank override.
module seg7_decode
    import ram_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/ram_display_bridge.sv
// Single-port RAM shared by a host channel and a periodic scan engine that
// refreshes LED and seven-segment displays; clears the RAM after reset.
module ram_display_bridge
    import ram_display_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int NUM_HEX    = 6,
    parameter int LED_W      = 10,
    parameter int LED_ADDR   = 0,
    parameter int HEX_BASE   = 2,
    parameter int SCAN_DIV   = 50000,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_ready,
    output logic                 host_rvalid,
    output logic [DATA_W-1:0]    host_rdata,
    output logic                 init_done,
    output logic                 scan_busy,
    output logic [LED_W-1:0]     leds,
    output logic [7*NUM_HEX-1:0] hex
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int SCAN_N = NUM_HEX + 2;
    localparam int IDX_W  = $clog2(SCAN_N + 1);
    localparam int TMR_W  = $clog2(SCAN_DIV);
    localparam int STV_W  = $clog2(STARVE_MAX + 1);

    if (DATA_W < 5) begin : g_bad_data_w
        $error("DATA_W must be at least 5");
    end
    if (HEX_BASE + NUM_HEX > DEPTH) begin : g_bad_hex_range
        $error("hex digit range exceeds RAM depth");
    end
    if (LED_ADDR + 1 >= DEPTH) begin : g_bad_led_addr
        $error("LED word pair exceeds RAM depth");
    end
    if (LED_W > 2*DATA_W) begin : g_bad_led_w
        $error("LED_W wider than two RAM words");
    end
    if (LED_ADDR <= HEX_BASE + NUM_HEX - 1 && LED_ADDR + 1 >= HEX_BASE) begin : g_bad_overlap
        $error("LED words overlap hex digit words");
    end

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
    logic                 init_done_q, init_done_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 pending_q, pending_d;
    logic [IDX_W-1:0]     issue_idx_q, issue_idx_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 scan_rvalid_q, scan_rvalid_d;
    logic [IDX_W-1:0]     scan_ridx_q, scan_ridx_d;
    logic                 host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0]    host_hold_q, host_hold_d;
    logic [LED_W-1:0]     leds_q, leds_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d, hex_dec;
    logic [DATA_W-1:0]    shadow_q [SCAN_N];
    logic [DATA_W-1:0]    shadow_d [SCAN_N];

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    ram_rdata_q;
    logic                 ram_en, ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_wdata;

    logic scan_want, stall, host_fire, scan_fire, last_ret;

    function automatic logic [ADDR_W-1:0] scan_addr(input logic [IDX_W-1:0] idx);
        if (idx == '0)             return ADDR_W'(LED_ADDR);
        else if (idx == IDX_W'(1)) return ADDR_W'(LED_ADDR + 1);
        else                       return ADDR_W'(HEX_BASE + int'(idx) - 2);
    endfunction

    // The host wins every contested cycle until the scan has lost STARVE_MAX in a row.
    assign scan_want  = (state_q == ST_SCAN) && (issue_idx_q < IDX_W'(SCAN_N));
    assign stall      = scan_want && (starve_q == STV_W'(STARVE_MAX));
    assign host_ready = (state_q == ST_IDLE) || ((state_q == ST_SCAN) && !stall);
    assign host_fire  = host_req && host_ready;
    assign scan_fire  = scan_want && !host_fire;
    assign last_ret   = scan_rvalid_q && (scan_ridx_q == IDX_W'(SCAN_N - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        if (state_q == ST_CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr_q;
            ram_wdata = '0;
        end else if (host_fire) begin
            ram_en = 1'b1;
            ram_we = host_we;
        end else if (scan_fire) begin
            ram_en   = 1'b1;
            ram_addr = scan_addr(issue_idx_q);
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        init_done_d   = init_done_q;
        timer_d       = timer_q;
        pending_d     = pending_q;
        issue_idx_d   = issue_idx_q;
        starve_d      = starve_q;
        scan_rvalid_d = scan_fire;
        scan_ridx_d   = issue_idx_q;
        host_rvalid_d = host_fire && !host_we;
        host_hold_d   = host_rvalid_q ? ram_rdata_q : host_hold_q;

        // Expiries during a scan are dropped, never queued.
        if (init_done_q) begin
            if (timer_q == '0) begin
                timer_d = TMR_W'(SCAN_DIV - 1);
                if (state_q != ST_SCAN) pending_d = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                starve_d = '0;
                if (pending_q) begin
                    state_d     = ST_SCAN;
                    pending_d   = 1'b0;
                    issue_idx_d = '0;
                end
            end
            ST_SCAN: begin
                if (scan_fire) begin
                    issue_idx_d = issue_idx_q + 1'b1;
                    starve_d    = '0;
                end else if (scan_want) begin
                    starve_d = starve_q + 1'b1;
                end
                if (last_ret) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (scan_rvalid_q) shadow_d[scan_ridx_q] = ram_rdata_q;
    end

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_digit
        seg7_decode u_seg7_decode (
            .nibble (shadow_d[i+2][3:0]),
            .blank  (shadow_d[i+2][DATA_W-1]),
            .seg    (hex_dec[7*i +: 7])
        );
    end

    // Both displays load from the same shadow snapshot in one cycle.
    always_comb begin
        leds_d = leds_q;
        hex_d  = hex_q;
        if (last_ret) begin
            leds_d = LED_W'({shadow_d[1], shadow_d[0]});
            hex_d  = hex_dec;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= '0;
            init_done_q   <= 1'b0;
            timer_q       <= TMR_W'(SCAN_DIV - 1);
            pending_q     <= 1'b0;
            issue_idx_q   <= '0;
            starve_q      <= '0;
            scan_rvalid_q <= 1'b0;
            scan_ridx_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_hold_q   <= '0;
            leds_q        <= '0;
            hex_q         <= '1;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            init_done_q   <= init_done_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            issue_idx_q   <= issue_idx_d;
            starve_q      <= starve_d;
            scan_rvalid_q <= scan_rvalid_d;
            scan_ridx_q   <= scan_ridx_d;
            host_rvalid_q <= host_rvalid_d;
            host_hold_q   <= host_hold_d;
            leds_q        <= leds_d;
            hex_q         <= hex_d;
        end
    end

    // NOTE: RAM and shadow words have no reset; CLEAR rewrites the RAM and every
    // scan rewrites all shadow words before the displays load from them.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata_q   <= mem[ram_addr];
        end
        shadow_q <= shadow_d;
    end

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_hold_d;
    assign init_done   = init_done_q;
    assign scan_busy   = (state_q == ST_SCAN);
    assign leds        = leds_q;
    assign hex         = hex_q;

endmodule

// File: tb/tb_ram_display_bridge.sv
// Self-checking bench: a word-level RAM/display model checked every cycle,
// plus directed host traffic with hand-computed expectations.
module tb_ram_display_bridge;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 6;
    localparam int NUM_HEX    = 6;
    localparam int LED_W      = 10;
    localparam int LED_ADDR   = 0;
    localparam int HEX_BASE   = 2;
    localparam int SCAN_DIV   = 200;
    localparam int STARVE_MAX = 8;
    localparam int DEPTH      = 64;
    localparam int SCAN_N     = NUM_HEX + 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 host_req, host_we;
    logic [ADDR_W-1:0]    host_addr;
    logic [DATA_W-1:0]    host_wdata;
    logic                 host_ready, host_rvalid, init_done, scan_busy;
    logic [DATA_W-1:0]    host_rdata;
    logic [LED_W-1:0]     leds;
    logic [7*NUM_HEX-1:0] hex;

    always #5 clk = ~clk;

    ram_display_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_HEX(NUM_HEX), .LED_W(LED_W),
        .LED_ADDR(LED_ADDR), .HEX_BASE(HEX_BASE), .SCAN_DIV(SCAN_DIV),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .init_done(init_done), .scan_busy(scan_busy),
        .leds(leds), .hex(hex)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [6:0] seg_of(input logic [7:0] w);
        if (w[7]) return 7'h7F;
        case (w[3:0])
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference model state, owned by the compare process.
    logic [DATA_W-1:0]    m_mem [DEPTH];
    logic [LED_W-1:0]     exp_leds;
    logic [7*NUM_HEX-1:0] exp_hex;
    logic                 rd_pend, busy_prev;
    logic [DATA_W-1:0]    rd_exp, rd_last;
    int                   rem, lost, tail;
    int                   cyc = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_leds", 64'(leds), 64'd0);
            check("rst_hex", 64'(hex), 64'({7*NUM_HEX{1'b1}}));
            check("rst_ready", 64'(host_ready), 64'd0);
            check("rst_rvalid", 64'(host_rvalid), 64'd0);
            check("rst_rdata", 64'(host_rdata), 64'd0);
            check("rst_init_done", 64'(init_done), 64'd0);
            check("rst_busy", 64'(scan_busy), 64'd0);
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            exp_leds  = '0;
            exp_hex   = '1;
            rd_pend   = 1'b0;
            rd_exp    = '0;
            rd_last   = '0;
            rem       = 0;
            lost      = 0;
            tail      = 0;
            busy_prev = 1'b0;
        end else begin
            check("init_done", 64'(init_done), 64'(cyc >= 64));
            if (!init_done) check("clear_ready", 64'(host_ready), 64'd0);

            check("rvalid", 64'(host_rvalid), 64'(rd_pend));
            check("rdata", 64'(host_rdata), 64'(rd_pend ? rd_exp : rd_last));
            if (rd_pend) rd_last = rd_exp;

            if (busy_prev && !scan_busy) begin
                exp_leds = LED_W'({m_mem[LED_ADDR+1], m_mem[LED_ADDR]});
                for (int i = 0; i < NUM_HEX; i++) exp_hex[7*i +: 7] = seg_of(m_mem[HEX_BASE+i]);
                check("scan_tail", 64'(tail), 64'd1);
            end
            check("leds", 64'(leds), 64'(exp_leds));
            check("hex", 64'(hex), 64'(exp_hex));

            if (scan_busy) begin
                if (!busy_prev) begin
                    rem  = SCAN_N;
                    lost = 0;
                    tail = 0;
                end
                check("scan_ready", 64'(host_ready), 64'(!(rem > 0 && lost == STARVE_MAX)));
                if (rem > 0) begin
                    if (host_req && host_ready) lost++;
                    else begin
                        rem--;
                        lost = 0;
                    end
                end else begin
                    tail++;
                end
            end else if (init_done) begin
                check("idle_ready", 64'(host_ready), 64'd1);
            end

            rd_pend = host_req && host_ready && !host_we;
            if (rd_pend) rd_exp = m_mem[host_addr];
            if (host_req && host_ready && host_we) m_mem[host_addr] = host_wdata;
            busy_prev = scan_busy;
        end
    end

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int t = 0;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        while (!host_ready && t < 500) begin @(negedge clk); t++; end
        check("wr_grant", 64'(host_ready), 64'd1);
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        int t = 0;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        while (!host_ready && t < 500) begin @(negedge clk); t++; end
        check("rd_grant", 64'(host_ready), 64'd1);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        d = host_rdata;
    endtask

    task automatic wait_scan(output logic [LED_W-1:0] leds_mid);
        int t = 0;
        while (!scan_busy && t < 3*SCAN_DIV) begin @(negedge clk); t++; end
        check("scan_start", 64'(scan_busy), 64'd1);
        leds_mid = leds;
        t = 0;
        while (scan_busy && t < 500) begin @(negedge clk); t++; end
        check("scan_end", 64'(scan_busy), 64'd0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [LED_W-1:0]  lm;
        logic [ADDR_W-1:0] rd_addrs [3];
        int                n, drops, t;
        logic              seen, acc;

        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        wait_init(n);
        check("init_cycles", 64'(n), 64'd64);
        check("ready_after_init", 64'(host_ready), 64'd1);

        rd_addrs[0] = 6'd0; rd_addrs[1] = 6'd31; rd_addrs[2] = 6'd63;
        for (int i = 0; i < 3; i++) begin
            host_read(rd_addrs[i], d);
            check($sformatf("clr_read_%0d", rd_addrs[i]), 64'(d), 64'h00);
        end

        wait_scan(lm);
        check("zero_leds", 64'(leds), 64'd0);
        check("zero_dig0", 64'(hex[6:0]), 64'h40);

        host_write(6'd2, 8'h0A);
        wait_scan(lm);
        check("dig0_A", 64'(hex[6:0]), 64'b0001000);

        host_write(6'd3, 8'h03);
        wait_scan(lm);
        check("dig1_3", 64'(hex[13:7]), 64'b0110000);

        host_write(6'd4, 8'h80);
        wait_scan(lm);
        check("dig2_blank", 64'(hex[20:14]), 64'h7F);
        for (int i = 3; i < NUM_HEX; i++)
            check($sformatf("dig%0d_zero", i), 64'(hex[7*i +: 7]), 64'b1000000);

        host_write(6'd0, 8'hFF);
        host_write(6'd1, 8'h03);
        wait_scan(lm);
        check("leds_old_mid_scan", 64'(lm), 64'd0);
        check("leds_3ff", 64'(leds), 64'h3FF);

        // Back-to-back host reads held across a whole scan.
        drops = 0; t = 0; seen = 1'b0;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = '0;
        while (t < 3*SCAN_DIV) begin
            @(negedge clk);
            acc = host_ready;
            if (scan_busy) begin
                seen = 1'b1;
                if (!host_ready) drops++;
            end else if (seen) begin
                break;
            end
            @(posedge clk); #1;
            if (acc) host_addr = host_addr + 1'b1;
            t++;
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        check("hold_scan_seen", 64'(seen), 64'd1);
        check("hold_stall_drops", 64'(drops), 64'(SCAN_N));

        // Reset in the middle of a scan with a host read in flight.
        host_write(6'd10, 8'h55);
        t = 0;
        while (!scan_busy && t < 3*SCAN_DIV) begin @(negedge clk); t++; end
        check("scan_for_reset", 64'(scan_busy), 64'd1);
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd10;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_leds", 64'(leds), 64'd0);
        check("async_rst_hex", 64'(hex), 64'({7*NUM_HEX{1'b1}}));
        check("async_rst_rvalid", 64'(host_rvalid), 64'd0);
        host_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_init(n);
        check("reinit_cycles", 64'(n), 64'd64);
        host_read(6'd10, d);
        check("rd10_after_reset", 64'(d), 64'h00);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
